// File: rtl/yarp_pkg.sv
// yarp_pkg: shared LSU types and lane helpers
package yarp_pkg;
   typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10} mem_size_e;
   typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, FIN} lsu_state_e;
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      return (size == 2'b11) || (size == HALF && off[0]) || (size == WORD && off != 2'b00);
   endfunction
   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
      return size == BYTE ? 4'b0001 << off : size == HALF ? 4'b0011 << off : 4'b1111;
   endfunction
   function automatic logic [31:0] lanes(input logic [1:0] size, input logic [31:0] wd);
      return size == BYTE ? {4{wd[7:0]}} : size == HALF ? {2{wd[15:0]}} : wd;
   endfunction
endpackage

// File: rtl/yarp_lsu_rdata_ext.sv
// yarp_lsu_rdata_ext: selects the load lane by byte offset and sign/zero-extends it
module yarp_lsu_rdata_ext
   import yarp_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  offset_i,
   input  mem_size_e   size_i,
   input  logic        zext_i,
   output logic [31:0] data_o
);
   logic [31:0] lane;
   // shift the addressed lane down to bit 0, then extend per access size
   always_comb begin
      lane = rdata_i >> {offset_i, 3'b000};
      data_o = size_i == BYTE ? {{24{~zext_i & lane[7]}}, lane[7:0]} :
               size_i == HALF ? {{16{~zext_i & lane[15]}}, lane[15:0]} : rdata_i;
   end
endmodule

// File: rtl/yarp_lsu.sv
// yarp_lsu: load/store unit running a req/gnt/rvalid transaction on the data-memory port
module yarp_lsu
   import yarp_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [1:0]        size_i,
   input  logic              zero_ext_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [3:0]        mem_be_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i
);
   if (DATA_W != 32) begin : g_bad_width
      $error("yarp_lsu supports DATA_W=32 only");
   end
   lsu_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        off_q;
   mem_size_e         size_q;
   logic              zext_q, we_q, err_q, mem_req_q, done_q, err_pulse_q;
   logic [3:0]        be_q;
   logic [31:0]       wdata_q, rdata_q, ext;
   logic              bad;
   yarp_lsu_rdata_ext u_ext (
      .rdata_i  (mem_rdata_i),
      .offset_i (off_q),
      .size_i   (size_q),
      .zext_i   (zext_q),
      .data_o   (ext)
   );
   // next-state logic; illegal/misaligned requests skip memory and go straight to FIN
   always_comb begin
      bad = misaligned(size_i, addr_i[1:0]);
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = req_i ? (bad ? FIN : REQ) : IDLE;
         REQ:     state_d = mem_gnt_i ? (we_q ? FIN : WAIT_RD) : REQ;
         WAIT_RD: state_d = mem_rvalid_i ? FIN : WAIT_RD;
         default: state_d = IDLE;
      endcase
   end
   // state, transaction capture, memory request and completion registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         off_q       <= '0;
         size_q      <= BYTE;
         zext_q      <= 1'b0;
         we_q        <= 1'b0;
         be_q        <= '0;
         wdata_q     <= '0;
         err_q       <= 1'b0;
         mem_req_q   <= 1'b0;
         done_q      <= 1'b0;
         err_pulse_q <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= state_d == REQ;
         done_q      <= state_q == FIN;
         err_pulse_q <= state_q == FIN && err_q;
         if (state_q == IDLE && req_i) begin
            err_q <= bad;
            if (!bad) begin
               addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
               off_q   <= addr_i[1:0];
               size_q  <= mem_size_e'(size_i);
               zext_q  <= zero_ext_i;
               we_q    <= we_i;
               be_q    <= byte_en(size_i, addr_i[1:0]);
               wdata_q <= lanes(size_i, wdata_i);
            end
         end
         if (state_q == WAIT_RD && mem_rvalid_i) rdata_q <= ext;
      end
   end
   assign busy_o      = state_q != IDLE;
   assign done_o      = done_q;
   assign err_o       = err_pulse_q;
   assign rdata_o     = rdata_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_be_o    = be_q;
   assign mem_wdata_o = wdata_q;
endmodule

// File: tb/tb_yarp_lsu.sv
// tb_yarp_lsu: scoreboard bench for yarp_lsu with a scripted memory responder
module tb_yarp_lsu;
   typedef struct {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wd;} mexp_t;
   typedef struct {logic err; logic [31:0] rd; int cyc;} dexp_t;
   logic clk = 1'b0, reset = 1'b1;
   logic req_i = 1'b0, we_i = 1'b0, zero_ext_i = 1'b0;
   logic [1:0] size_i = 2'b00;
   logic [31:0] addr_i = '0, wdata_i = '0;
   logic busy_o, done_o, err_o, mem_req_o, mem_we_o;
   logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
   logic [3:0] mem_be_o;
   logic mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   int cyc = 0, n_cmp = 0, n_bad = 0;
   int gnt_dly = 0, rv_dly = 1;
   logic [31:0] rd_word = '0;
   mexp_t mq[$];
   dexp_t dq[$];
   yarp_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i), .size_i(size_i),
      .zero_ext_i(zero_ext_i), .addr_i(addr_i), .wdata_i(wdata_i), .busy_o(busy_o),
      .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o), .mem_req_o(mem_req_o),
      .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
      .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, " busy_o"}, {31'd0, busy_o}, 32'd0);
      chk({tag, " done_o"}, {31'd0, done_o}, 32'd0);
      chk({tag, " err_o"}, {31'd0, err_o}, 32'd0);
      chk({tag, " rdata_o"}, rdata_o, 32'd0);
      chk({tag, " mem_req_o"}, {31'd0, mem_req_o}, 32'd0);
      chk({tag, " mem_we_o"}, {31'd0, mem_we_o}, 32'd0);
      chk({tag, " mem_addr_o"}, mem_addr_o, 32'd0);
      chk({tag, " mem_be_o"}, {28'd0, mem_be_o}, 32'd0);
      chk({tag, " mem_wdata_o"}, mem_wdata_o, 32'd0);
   endtask
   task automatic setin(input logic we, input logic [1:0] sz, input logic zx,
                        input logic [31:0] a, input logic [31:0] wd);
      we_i = we; size_i = sz; zero_ext_i = zx; addr_i = a; wdata_i = wd; req_i = 1'b1;
   endtask
   task automatic issue(input logic we, input logic [1:0] sz, input logic zx,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic has_mem, input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wd, input logic has_done, input int lat,
                        input logic e_err, input logic [31:0] e_rd);
      setin(we, sz, zx, a, wd);
      if (has_mem) mq.push_back('{we, e_addr, e_be, e_wd});
      if (has_done) dq.push_back('{e_err, e_rd, cyc + lat});
      tick();
      req_i = 1'b0;
   endtask
   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         if (!busy_o && dq.size() == 0 && mq.size() == 0) return;
         tick();
      end
      n_cmp++;
      n_bad++;
      $display("FAIL idle timeout: busy=%b done_q=%0d mem_q=%0d", busy_o, dq.size(), mq.size());
   endtask
   // memory responder: grant after gnt_dly cycles, return read data rv_dly cycles after grant
   initial begin
      logic w;
      forever begin
         @(posedge clk);
         #2;
         if (mem_req_o && !mem_gnt_i) begin
            repeat (gnt_dly) begin
               @(posedge clk);
               #2;
            end
            mem_gnt_i = 1'b1;
            w = mem_we_o;
            @(posedge clk);
            #2;
            mem_gnt_i = 1'b0;
            if (!w) begin
               repeat (rv_dly - 1) begin
                  @(posedge clk);
                  #2;
               end
               mem_rvalid_i = 1'b1;
               mem_rdata_i = rd_word;
               @(posedge clk);
               #2;
               mem_rvalid_i = 1'b0;
            end
         end
      end
   end
   // memory-port monitor: every requesting cycle must match the pending request; pop on grant
   always @(negedge clk) begin
      if (mem_req_o) begin
         if (mq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected mem_req_o: addr %h expected no request", mem_addr_o);
         end else begin
            chk("mem_we_o", {31'd0, mem_we_o}, {31'd0, mq[0].we});
            chk("mem_addr_o", mem_addr_o, mq[0].addr);
            chk("mem_be_o", {28'd0, mem_be_o}, {28'd0, mq[0].be});
            chk("mem_wdata_o", mem_wdata_o, mq[0].wd);
            if (mem_gnt_i) void'(mq.pop_front());
         end
      end
   end
   // completion monitor: pop expected result whenever done_o pulses
   always @(negedge clk) begin
      if (err_o && !done_o) begin
         n_cmp++;
         n_bad++;
         $display("FAIL err_o without done_o: got 1 expected 0");
      end
      if (done_o) begin
         if (dq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected done_o: got 1 expected 0");
         end else begin
            dexp_t e;
            e = dq.pop_front();
            chk("err_o", {31'd0, err_o}, {31'd0, e.err});
            chk("rdata_o", rdata_o, e.rd);
            chk("done cycle", cyc, e.cyc);
         end
      end
   end
   initial begin
      repeat (3) tick();
      chk_zero("reset");
      reset = 1'b0;
      tick();
      // store byte, immediate grant
      gnt_dly = 0;
      issue(1, 2'b00, 0, 32'h1003, 32'hAABBCCDD, 1, 32'h1000, 4'b1000, 32'hDDDDDDDD, 1, 3, 0, 32'h0);
      wait_idle();
      // load half signed then zero-extended
      rv_dly = 1; rd_word = 32'h80011234;
      issue(0, 2'b01, 0, 32'h2002, 32'h0, 1, 32'h2000, 4'b1100, 32'h0, 1, 4, 0, 32'hFFFF8001);
      wait_idle();
      issue(0, 2'b01, 1, 32'h2002, 32'h0, 1, 32'h2000, 4'b1100, 32'h0, 1, 4, 0, 32'h00008001);
      wait_idle();
      // load word, grant delayed 3 cycles, rvalid 2 cycles after grant
      gnt_dly = 3; rv_dly = 2; rd_word = 32'hDEADBEEF;
      issue(0, 2'b10, 0, 32'h3000, 32'h0, 1, 32'h3000, 4'b1111, 32'h0, 1, 8, 0, 32'hDEADBEEF);
      for (int i = 0; i < 7; i++) begin
         chk("busy_o during slow load", {31'd0, busy_o}, 32'd1);
         tick();
      end
      wait_idle();
      gnt_dly = 0; rv_dly = 1;
      // misaligned and illegal accesses: no memory request, rdata_o untouched
      issue(0, 2'b10, 0, 32'h4002, 32'h0, 0, 32'h0, 4'h0, 32'h0, 1, 2, 1, 32'hDEADBEEF);
      wait_idle();
      issue(0, 2'b01, 0, 32'h8001, 32'h0, 0, 32'h0, 4'h0, 32'h0, 1, 2, 1, 32'hDEADBEEF);
      wait_idle();
      issue(1, 2'b11, 0, 32'h8000, 32'h12345678, 0, 32'h0, 4'h0, 32'h0, 1, 2, 1, 32'hDEADBEEF);
      wait_idle();
      chk("rdata_o after errors", rdata_o, 32'hDEADBEEF);
      // reset while waiting for read data; late rvalid must be ignored
      rv_dly = 2; rd_word = 32'h12345678;
      issue(0, 2'b10, 0, 32'h6000, 32'h0, 1, 32'h6000, 4'b1111, 32'h0, 0, 0, 0, 32'h0);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_zero("mid reset");
      repeat (4) tick();
      chk("busy_o after late rvalid", {31'd0, busy_o}, 32'd0);
      chk("rdata_o after late rvalid", rdata_o, 32'd0);
      rv_dly = 1; rd_word = 32'h00007F00;
      issue(0, 2'b00, 0, 32'h5001, 32'h0, 1, 32'h5000, 4'b0010, 32'h0, 1, 4, 0, 32'h0000007F);
      wait_idle();
      rd_word = 32'h00000080;
      issue(0, 2'b00, 0, 32'h9000, 32'h0, 1, 32'h9000, 4'b0001, 32'h0, 1, 4, 0, 32'hFFFFFF80);
      wait_idle();
      // back-to-back: req_i held high across a store then a load
      rd_word = 32'hAB000000;
      setin(1, 2'b01, 0, 32'h7002, 32'h0000BEEF);
      mq.push_back('{1'b1, 32'h7000, 4'b1100, 32'hBEEFBEEF});
      dq.push_back('{1'b0, 32'hFFFFFF80, cyc + 3});
      mq.push_back('{1'b0, 32'h7000, 4'b1000, 32'h0});
      dq.push_back('{1'b0, 32'h000000AB, cyc + 7});
      tick();
      setin(0, 2'b00, 1, 32'h7003, 32'h0);
      chk("busy_o b2b T+1", {31'd0, busy_o}, 32'd1);
      tick();
      chk("busy_o b2b T+2", {31'd0, busy_o}, 32'd1);
      tick();
      chk("busy_o b2b T+3", {31'd0, busy_o}, 32'd0);
      tick();
      req_i = 1'b0;
      wait_idle();
      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
